pzcorebus_memory_slave: RTL

- Synthesizable corebus slave terminating one corebus port.
- Sits directly downstream of the corebus master/VIP interface: consumes the command and write-data channels, produces the response channel.
- Backed by a word-addressed register-array memory.
- Used as a DUT-side endpoint and as a reference responder in corebus benches.

---
 rtl/pzcorebus_memory_slave_pkg.sv | 35 +++
 rtl/pzcorebus_memory_slave_ram.sv | 26 ++
 rtl/pzcorebus_memory_slave.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pzcorebus_memory_slave_pkg.sv
// Shared types and helpers for the corebus memory slave.
package pzcorebus_memory_slave_pkg;

  typedef enum logic [1:0] {
    CMD_READ             = 2'd0,
    CMD_WRITE            = 2'd1,
    CMD_WRITE_NON_POSTED = 2'd2,
    CMD_RESERVED         = 2'd3
  } command_t;

  typedef enum logic {
    RESP_RESPONSE  = 1'b0,
    RESP_WITH_DATA = 1'b1
  } response_t;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WRITE_DATA = 2'd1,
    ST_WRITE_RESP = 2'd2,
    ST_READ_RESP  = 2'd3
  } state_t;

  // A length of zero encodes the maximum burst of 2**length_width beats.
  function automatic int unsigned calc_beats(input int unsigned length,
                                             input int unsigned length_width);
    return (length == 0) ? (32'd1 << length_width) : length;
  endfunction

  function automatic logic [63:0] word_index(input logic [63:0] addr,
                                             input logic [63:0] base,
                                             input int unsigned bytes_per_word);
    return (addr - base) / 64'(bytes_per_word);
  endfunction

endpackage

// File: rtl/pzcorebus_memory_slave_ram.sv
// Word-wide register-array memory: byte-enabled synchronous write, combinational read.
module pzcorebus_memory_slave_ram #(
  parameter int DATA_WIDTH   = 64,
  parameter int MEMORY_DEPTH = 256
) (
  input  logic                            clk,
  input  logic                            write,
  input  logic [$clog2(MEMORY_DEPTH)-1:0] index,
  input  logic [DATA_WIDTH-1:0]           wdata,
  input  logic [DATA_WIDTH/8-1:0]         byteen,
  output logic [DATA_WIDTH-1:0]           rdata
);

  logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

  always_ff @(posedge clk) begin
    if (write) begin
      for (int b = 0; b < DATA_WIDTH / 8; b++) begin
        if (byteen[b]) mem[index][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem[index];

endmodule

// File: rtl/pzcorebus_memory_slave.sv
// Corebus slave endpoint terminating one port onto a word-addressed memory.
// state         | meaning
// ST_IDLE       | waiting for a command (accept registered, one cycle behind IDLE entry)
// ST_WRITE_DATA | consuming write beats until count or mdata_last ends the burst
// ST_WRITE_RESP | single response for a non-posted write
// ST_READ_RESP  | streaming read beats, one per accepted response
module pzcorebus_memory_slave
  import pzcorebus_memory_slave_pkg::*;
#(
  parameter int                       ID_WIDTH      = 8,
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 64,
  parameter int                       LENGTH_WIDTH  = 4,
  parameter int                       MEMORY_DEPTH  = 256,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS  = '0
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_mcmd_valid,
  output logic                      o_scmd_accept,
  input  logic [1:0]                i_mcmd,
  input  logic [ID_WIDTH-1:0]       i_mid,
  input  logic [ADDRESS_WIDTH-1:0]  i_maddr,
  input  logic [LENGTH_WIDTH-1:0]   i_mlength,
  input  logic                      i_mdata_valid,
  output logic                      o_sdata_accept,
  input  logic [DATA_WIDTH-1:0]     i_mdata,
  input  logic [DATA_WIDTH/8-1:0]   i_mdata_byteen,
  input  logic                      i_mdata_last,
  output logic                      o_sresp_valid,
  input  logic                      i_mresp_accept,
  output logic                      o_sresp,
  output logic [ID_WIDTH-1:0]       o_sid,
  output logic                      o_serror,
  output logic [DATA_WIDTH-1:0]     o_sdata,
  output logic                      o_sresp_last,
  output logic                      o_busy,
  output logic                      o_protocol_error
);

  localparam int BW = LENGTH_WIDTH + 1;
  localparam int IW = $clog2(MEMORY_DEPTH);

  state_t                state, state_next;
  command_t              cmd;
  logic                  accept_q;
  logic                  perr_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [IW-1:0]         index_q;
  logic [BW-1:0]         remaining_q;
  logic                  is_np_q;
  logic                  error_q;

  logic                  cmd_hs, data_hs, resp_hs;
  logic                  final_beat, end_write, is_write_cmd;
  logic [63:0]           cmd_index;
  logic                  cmd_error;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign cmd          = command_t'(i_mcmd);
  assign is_write_cmd = (cmd == CMD_WRITE) || (cmd == CMD_WRITE_NON_POSTED);
  assign cmd_hs       = i_mcmd_valid && accept_q;
  assign data_hs      = i_mdata_valid && o_sdata_accept;
  assign resp_hs      = o_sresp_valid && i_mresp_accept;
  assign final_beat   = (remaining_q == BW'(1));
  assign end_write    = final_beat || i_mdata_last;

  assign cmd_index = word_index(64'(i_maddr), 64'(BASE_ADDRESS), DATA_WIDTH / 8);
  assign cmd_error = (i_maddr < BASE_ADDRESS) ||
                     (cmd_index >= 64'(MEMORY_DEPTH)) ||
                     (cmd == CMD_RESERVED);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:       if (cmd_hs) state_next = is_write_cmd ? ST_WRITE_DATA : ST_READ_RESP;
      ST_WRITE_DATA: if (data_hs && end_write) state_next = is_np_q ? ST_WRITE_RESP : ST_IDLE;
      ST_WRITE_RESP: if (resp_hs) state_next = ST_IDLE;
      ST_READ_RESP:  if (resp_hs && final_beat) state_next = ST_IDLE;
      default:       state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_sdata_accept = 1'b0;
    o_sresp_valid  = 1'b0;
    o_sresp        = RESP_RESPONSE;
    o_sid          = '0;
    o_serror       = 1'b0;
    o_sdata        = '0;
    o_sresp_last   = 1'b0;
    case (state)
      ST_WRITE_DATA: o_sdata_accept = 1'b1;
      ST_WRITE_RESP: begin
        o_sresp_valid = 1'b1;
        o_sid         = id_q;
        o_serror      = error_q;
        o_sresp_last  = 1'b1;
      end
      ST_READ_RESP: begin
        o_sresp_valid = 1'b1;
        o_sresp       = RESP_WITH_DATA;
        o_sid         = id_q;
        o_serror      = error_q;
        o_sdata       = error_q ? '0 : ram_rdata;
        o_sresp_last  = final_beat;
      end
      default: ;
    endcase
  end

  // Accept drops on the handshake edge so only one command enters per IDLE visit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      accept_q    <= 1'b0;
      perr_q      <= 1'b0;
      id_q        <= '0;
      index_q     <= '0;
      remaining_q <= '0;
      is_np_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      accept_q <= (state == ST_IDLE) && !cmd_hs;
      perr_q   <= (cmd_hs && (cmd == CMD_RESERVED)) ||
                  (data_hs && (i_mdata_last != final_beat));
      if (cmd_hs) begin
        id_q        <= i_mid;
        index_q     <= cmd_index[IW-1:0];
        remaining_q <= BW'(calc_beats(32'(i_mlength), LENGTH_WIDTH));
        is_np_q     <= (cmd == CMD_WRITE_NON_POSTED);
        error_q     <= cmd_error;
      end else if (data_hs || resp_hs) begin
        index_q     <= index_q + IW'(1);
        remaining_q <= remaining_q - BW'(1);
      end
    end
  end

  assign o_scmd_accept    = accept_q;
  assign o_protocol_error = perr_q;
  assign o_busy           = (state != ST_IDLE);

  pzcorebus_memory_slave_ram #(
    .DATA_WIDTH   (DATA_WIDTH),
    .MEMORY_DEPTH (MEMORY_DEPTH)
  ) u_ram (
    .clk    (i_clk),
    .write  (data_hs && !error_q),
    .index  (index_q),
    .wdata  (i_mdata),
    .byteen (i_mdata_byteen),
    .rdata  (ram_rdata)
  );

endmodule
